vga_scanout: RTL and testbench
==============================

# vga_scanout

Video output stage at the consumer end of the scanline pixel FIFO. The line renderer fills this FIFO with 16-bit RGB565 pixels, one scanline at a time. This block generates 640x480@60 VGA timing and pops one FIFO word per visible pixel. It drives registered sync and colour pins and pulses `trigger` once per frame so the renderer starts the next frame. During vertical front porch it drains leftover FIFO words, so every frame starts aligned.

## Interface

Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk`  in  1  pixel clock, one pixel per cycle
- `rst_n`  in  1  asynchronous, active-low reset
- `fifo_empty`  in  1  pixel FIFO empty
- `fifo_data`  in  16  FIFO read data, valid the cycle after `fifo_read` (non-show-ahead)
- `fifo_read`  out  1  FIFO pop strobe
- `trigger`  out  1  one-cycle frame-start pulse to the renderer
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `red`  out  5  `fifo_data[15:11]`
- `green`  out  6  `fifo_data[10:5]`
- `blue`  out  5  `fifo_data[4:0]`
- `underflow`  out  1  sticky underflow flag (see Configuration)

## Operation

Counters:
- `hcnt` runs 0..H_TOTAL-1, with H_TOTAL = 800.
- `vcnt` runs 0..V_TOTAL-1, with V_TOTAL = 525.
- `vcnt` increments when `hcnt` wraps. Both wrap to 0.
- Width is 10 bits each; there is no overflow path.

Region classification is combinational from the counters:
- **VISIBLE**: `hcnt`<640 and `vcnt`<480
- **DRAIN**: 480≤`vcnt`<490
- **SYNC**: 490≤`vcnt`<492
- **BACK**: 492≤`vcnt`<525
- Horizontal blanking within lines 0..479 is **HBLANK**.

Per-region behaviour:
- **VISIBLE**: `fifo_read` = !`fifo_empty`.
  - A pixel with `fifo_empty`=1 is an underflow. No pop occurs, and the fill colour is displayed for that pixel.
- **DRAIN**: `fifo_read` = !`fifo_empty` on every cycle. Popped data is discarded and colour outputs are 0.
- **SYNC, BACK, HBLANK**: `fifo_read`=0.

`trigger`:
- Pulses high for exactly one cycle when `hcnt`==0 and `vcnt`==490, i.e. on the first cycle of vsync.
- This gives the renderer 35 lines of lead time before line 0.

Sync generation:
- `hsync` is low for 656≤`hcnt`<752.
- `vsync` is low for 490≤`vcnt`<492.

Reset (`rst_n` low, asynchronous):
- Counters: `hcnt`=0, `vcnt`=480, so the block starts at the beginning of DRAIN.
- Outputs: `fifo_read`=0, `trigger`=0, `hsync`=1, `vsync`=1, colour=0, `underflow`=0.
- Pipeline registers are cleared to the blank and sync-inactive state.
- Reset mid-frame abandons the frame. Leftover FIFO words are drained in the following DRAIN region before the next `trigger`.
- The first `trigger` after reset release therefore occurs 10 lines (8000 cycles) later.

## Timing

- Stage 0 (cycle N): counters decoded and `fifo_read` issued combinationally.
- Stage 1 (N+1): `fifo_data` is registered into the colour stage. Blank and underflow status from N are carried alongside it.
- Stage 2 (N+2): `red`/`green`/`blue`, `hsync` and `vsync` are valid on registered outputs.
- Pipeline rules:
  - Sync signals are delayed 2 cycles so they align with colour.
  - Latency from counter position to pins is 2 cycles.
  - `trigger` is not delayed.
- `fifo_read` is combinational from registered counters and `fifo_empty`. It never asserts outside VISIBLE and DRAIN.
- Colour outputs are 0 whenever the delayed position is not VISIBLE.
- Simultaneous pop and renderer write to the FIFO is legal. `fifo_empty` is sampled as presented.

## Configuration

`VGA_SCANOUT_UNDERFLOW_EN`

Defined:
- An underflowed visible pixel displays magenta, 16'hF81F.
- `underflow` goes high at stage 2 of the first underflowed pixel and stays high.
- The flag clears on `trigger` (the same cycle) or on reset.

Undefined:
- An underflowed pixel displays black (0).
- `underflow` is tied to 0.
- No underflow logic is synthesised.

## Test plan

- **Reset values**: assert `rst_n`=0 mid-line, then release.
  - During reset: `hsync`=`vsync`=1, colour 0, `fifo_read`=0, `underflow`=0.
  - After release: first `trigger` exactly 8000 cycles later, single-cycle.
- **Sync timing**: free-run with FIFO empty for 2 frames.
  - `hsync` low 96 cycles every 800 cycles, starting at `hcnt` 656 + 2 cycles latency.
  - `vsync` low for 1600 cycles every 420000 cycles.
  - `trigger` period is 420000 cycles.
- **Pixel path**: model the FIFO preloaded with 640 words of value k for line k, then refill per line.
  - Pins show 16'h0000 for line 0 and 16'h0001 for line 1.
  - Colour appears starting 2 cycles after `hcnt`=0.
  - Exactly 640 pops per line and no underflow.
- **Drain**: leave 37 extra words in the FIFO at the end of line 479.
  - 37 consecutive `fifo_read` pulses occur starting at `vcnt`=480, `hcnt`=0.
  - FIFO is empty before `trigger`, and colour stays 0.
- **Underflow with macro defined**: hold `fifo_empty`=1 for pixels 100..103 of line 5.
  - Pins show 16'hF81F for 4 pixels.
  - `underflow` rises and stays set until the next `trigger`.
  - The next words resume at pixel 104.
- **Underflow with macro undefined**: same stimulus.
  - Pixels show 0 and `underflow` stays 0.

Source files
------------

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: pops RGB565 pixels from the line FIFO, drives registered sync/colour pins.
// Optional VGA_SCANOUT_UNDERFLOW_EN: magenta fill and sticky underflow flag on FIFO starvation.
module vga_scanout #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data,
    output logic        fifo_read,
    output logic        trigger,
    output logic        hsync,
    output logic        vsync,
    output logic [4:0]  red,
    output logic [5:0]  green,
    output logic [4:0]  blue,
    output logic        underflow
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [2:0] {
        REG_VISIBLE,
        REG_HBLANK,
        REG_DRAIN,
        REG_SYNC,
        REG_BACK
    } region_e;

    logic [9:0] hcnt;
    logic [9:0] vcnt;
    region_e    region;
    logic       hs_raw;
    logic       vs_raw;

    logic        s1_show;
    logic        s1_hs;
    logic        s1_vs;
    logic [15:0] rgb_q;

    // Reset lands at the start of the drain lines so leftovers are flushed before the first trigger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= V_VIS_END;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    always_comb begin
        region = REG_BACK;
        if (vcnt < V_VIS_END)
            region = (hcnt < H_VIS_END) ? REG_VISIBLE : REG_HBLANK;
        else if (vcnt < V_SYNC_BEG)
            region = REG_DRAIN;
        else if (vcnt < V_SYNC_END)
            region = REG_SYNC;
    end

    assign hs_raw = !((hcnt >= H_SYNC_BEG) && (hcnt < H_SYNC_END));
    assign vs_raw = !((vcnt >= V_SYNC_BEG) && (vcnt < V_SYNC_END));

    // Gated by rst_n so no pop can leak out while reset is held
    assign fifo_read = rst_n && !fifo_empty
                       && ((region == REG_VISIBLE) || (region == REG_DRAIN));
    assign trigger   = (hcnt == '0) && (vcnt == V_SYNC_BEG);

`ifdef VGA_SCANOUT_UNDERFLOW_EN
    logic s1_uf;
    logic uf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_show <= 1'b0;
            s1_uf   <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
        end else begin
            s1_show <= (region == REG_VISIBLE);
            s1_uf   <= (region == REG_VISIBLE) && fifo_empty;
            s1_hs   <= hs_raw;
            s1_vs   <= vs_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
            uf_q  <= 1'b0;
        end else begin
            hsync <= s1_hs;
            vsync <= s1_vs;
            if (!s1_show)
                rgb_q <= '0;
            else if (s1_uf)
                rgb_q <= 16'hF81F;
            else
                rgb_q <= fifo_data;
            if (trigger)
                uf_q <= 1'b0;
            else if (s1_show && s1_uf)
                uf_q <= 1'b1;
        end
    end

    // Masked by trigger so the flag reads clear in the trigger cycle itself
    assign underflow = uf_q && !trigger;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_show <= 1'b0;
            s1_hs   <= 1'b1;
            s1_vs   <= 1'b1;
        end else begin
            s1_show <= (region == REG_VISIBLE) && !fifo_empty;
            s1_hs   <= hs_raw;
            s1_vs   <= vs_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            hsync <= s1_hs;
            vsync <= s1_vs;
            rgb_q <= s1_show ? fifo_data : '0;
        end
    end

    assign underflow = 1'b0;
`endif

    assign red   = rgb_q[15:11];
    assign green = rgb_q[10:5];
    assign blue  = rgb_q[4:0];

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken 16x13 raster; FIFO modelled as a non-show-ahead queue.
module tb_vga_scanout;

    localparam int HV = 8, HF = 2, HS = 3, HB = 3;
    localparam int VV = 6, VF = 3, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;

`ifdef VGA_SCANOUT_UNDERFLOW_EN
    localparam logic [15:0] FILL = 16'hF81F;
    localparam logic        UFX  = 1'b1;
`else
    localparam logic [15:0] FILL = 16'h0000;
    localparam logic        UFX  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic [15:0] fifo_data = '0;
    logic        fifo_read, trigger, hsync, vsync, underflow;
    logic [4:0]  red, blue;
    logic [5:0]  green;
    logic        force_empty = 1'b0;

    logic [15:0] mem [0:1023];
    int rd = 0;
    int wr = 0;
    int nvec = 0;
    int nerr = 0;

    typedef struct {
        int          o;
        logic        frc;
        logic        rd;
        logic        trig;
        logic        hs;
        logic        vs;
        logic [15:0] rgb;
        logic        uf;
    } vec_t;

    vec_t tbl[$];

    vga_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_read(fifo_read), .trigger(trigger), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .underflow(underflow)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (rd == wr) || force_empty;

    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_data <= mem[rd % 1024];
            rd <= rd + 1;
        end
    end

    function automatic logic [31:0] cur();
        return {11'b0, fifo_read, trigger, hsync, vsync, red, green, blue, underflow};
    endfunction

    function automatic logic [31:0] pack(logic r, logic t, logic h, logic v, logic [15:0] c, logic u);
        return {11'b0, r, t, h, v, c, u};
    endfunction

    function automatic vec_t mk(int o, logic frc, logic r, logic t, logic h, logic v,
                                logic [15:0] c, logic u);
        vec_t x;
        x.o = o; x.frc = frc; x.rd = r; x.trig = t; x.hs = h; x.vs = v; x.rgb = c; x.uf = u;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr % 1024] = w;
        wr++;
    endtask

    task automatic push_frame(input logic [15:0] base, input int extra);
        for (int k = 0; k < VV; k++)
            for (int i = 0; i < HV; i++)
                push(base + 16'(k * 16 + i));
        for (int j = 0; j < extra; j++)
            push(16'hE000 + 16'(j));
    endtask

    task automatic wait_trigger(output int k);
        for (k = 1; k <= 500; k++) begin
            @(negedge clk);
            #1;
            if (trigger) break;
        end
    endtask

    initial begin
        int k;
        int o;
        logic [31:0] rst_vec;
        rst_vec = pack(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);

        // Offsets are cycles after the trigger; pins show the raster position two cycles earlier
        tbl.push_back(mk(  0, 0, 0, 1, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(  1, 0, 0, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(  2, 0, 0, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk( 11, 0, 0, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk( 12, 0, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk( 14, 0, 0, 0, 0, 0, 16'h0000, 0));
        tbl.push_back(mk( 15, 0, 0, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk( 33, 0, 0, 0, 1, 0, 16'h0000, 0));
        tbl.push_back(mk( 34, 0, 0, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk( 64, 0, 1, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk( 66, 0, 1, 0, 1, 1, 16'h1000, 0));
        tbl.push_back(mk( 73, 0, 0, 0, 1, 1, 16'h1007, 0));
        tbl.push_back(mk( 74, 0, 0, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk( 82, 0, 1, 0, 1, 1, 16'h1010, 0));
        tbl.push_back(mk( 89, 0, 0, 0, 1, 1, 16'h1017, 0));
        tbl.push_back(mk(153, 0, 0, 0, 1, 1, 16'h1057, 0));
        tbl.push_back(mk(160, 0, 1, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(172, 0, 1, 0, 0, 1, 16'h0000, 0));
        tbl.push_back(mk(180, 0, 1, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(196, 0, 1, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(197, 0, 0, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(208, 0, 0, 1, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(209, 0, 0, 0, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(274, 0, 1, 0, 1, 1, 16'h2000, 0));
        tbl.push_back(mk(354, 1, 0, 0, 1, 1, 16'h2050, 0));
        tbl.push_back(mk(355, 1, 0, 0, 1, 1, 16'h2051, 0));
        tbl.push_back(mk(356, 1, 0, 0, 1, 1, FILL,     UFX));
        tbl.push_back(mk(357, 1, 0, 0, 1, 1, FILL,     UFX));
        tbl.push_back(mk(358, 0, 1, 0, 1, 1, FILL,     UFX));
        tbl.push_back(mk(359, 0, 1, 0, 1, 1, FILL,     UFX));
        tbl.push_back(mk(360, 0, 0, 0, 1, 1, 16'h2052, UFX));
        tbl.push_back(mk(361, 0, 0, 0, 1, 1, 16'h2053, UFX));
        tbl.push_back(mk(362, 0, 0, 0, 1, 1, 16'h0000, UFX));
        tbl.push_back(mk(371, 0, 1, 0, 1, 1, 16'h0000, UFX));
        tbl.push_back(mk(372, 0, 0, 0, 1, 1, 16'h0000, UFX));
        tbl.push_back(mk(415, 0, 0, 0, 1, 1, 16'h0000, UFX));
        tbl.push_back(mk(416, 0, 0, 1, 1, 1, 16'h0000, 0));
        tbl.push_back(mk(417, 0, 0, 0, 1, 1, 16'h0000, 0));

        repeat (3) @(negedge clk);
        #1 check("reset_idle", cur(), rst_vec);

        @(negedge clk);
        rst_n = 1'b1;
        wait_trigger(k);
        check("first_trigger_latency", k, VF * HT);
        @(negedge clk);
        #1 check("trigger_single_cycle", {31'b0, trigger}, 32'd0);
        repeat (11) @(negedge clk);
        #1 check("sync_before_reset", {30'b0, hsync, vsync}, 32'd0);

        // Mid-line reset while in sync, with words left in the FIFO
        rst_n = 1'b0;
        #1 check("async_reset", cur(), rst_vec);
        for (int j = 0; j < 5; j++) push(16'hB000 + 16'(j));
        repeat (2) @(negedge clk);
        #1 check("reset_hold_no_pop", cur(), rst_vec);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("drain_after_release", {31'b0, fifo_read}, 32'd1);
        wait_trigger(k);
        check("trigger_latency_after_reset", k, VF * HT);
        check("fifo_drained_at_trigger", wr - rd, 0);

        push_frame(16'h1000, 37);
        o = 0;
        foreach (tbl[n]) begin
            while (o < tbl[n].o) begin
                @(negedge clk);
                o++;
                force_empty = 1'b0;
                if (o == 208) push_frame(16'h2000, 0);
            end
            force_empty = tbl[n].frc;
            #1 check($sformatf("vec@%0d", tbl[n].o), cur(),
                     pack(tbl[n].rd, tbl[n].trig, tbl[n].hs, tbl[n].vs, tbl[n].rgb, tbl[n].uf));
        end
        force_empty = 1'b0;
        check("total_pops", rd, 5 + 85 + 48);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
